sb_regfile: RTL and testbench
=============================

SB_REGFILE -- requirements
Module: sb_regfile

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the register data width in bits.
REQ-002 Parameter NUM_REGISTERS, default 32, SHALL set the register count; AW = $clog2(NUM_REGISTERS).
REQ-003 Parameter NUM_READ, default 2, SHALL set the number of independent read ports.
REQ-004 Parameter NUM_WRITE, default 2, SHALL set the number of independent write ports.
REQ-005 clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-006 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-007 rd_addr  input  NUM_READ*AW  SHALL carry the read addresses; port p uses slice [p*AW +: AW].
REQ-008 rd_data  output  NUM_READ*DATA_WIDTH  SHALL carry the read data per port, combinational.
REQ-009 rd_busy  output  NUM_READ  SHALL flag that port p's register awaits an outstanding write.
REQ-010 wr_en  input  NUM_WRITE  SHALL carry the per-port write enables.
REQ-011 wr_addr  input  NUM_WRITE*AW  SHALL carry the write addresses.
REQ-012 wr_data  input  NUM_WRITE*DATA_WIDTH  SHALL carry the write data.
REQ-013 iss_en  input  1  SHALL request that the destination register be marked busy (instruction issue).
REQ-014 iss_addr  input  AW  SHALL carry the destination register being issued.
REQ-015 busy  output  NUM_REGISTERS  SHALL present the registered scoreboard vector.
REQ-016 busy_count  output  AW+1  SHALL present the registered count of set busy bits.

Function
REQ-017 Register 0 SHALL read as zero, SHALL never be written, and SHALL never be marked busy.
REQ-018 On posedge clk, each port w with wr_en[w]=1 and wr_addr!=0 SHALL write wr_data into registers[wr_addr].
REQ-019 Two or more write ports targeting the same address in one cycle SHALL resolve with the highest-index port winning.
REQ-020 Read port p SHALL return the data of the highest-index enabled write port whose address equals rd_addr (nonzero) in the same cycle; otherwise it SHALL return the stored value.
REQ-021 rd_busy[p] SHALL equal busy[rd_addr] AND NOT (any enabled write port to rd_addr this cycle); rd_busy for address 0 SHALL be 0.
REQ-022 Busy bit r SHALL clear at posedge clk when any enabled write port targets r (r!=0).
REQ-023 Busy bit r SHALL set at posedge clk when iss_en=1 and iss_addr=r (r!=0).
REQ-024 Simultaneous issue and write to the same register SHALL leave the busy bit set (issue wins; the new producer is pending).
REQ-025 Issue of an already-busy register SHALL keep the bit set, with no error and no count change.
REQ-026 busy_count SHALL be updated in the same cycle as busy and SHALL always equal the popcount of busy; range 0..NUM_REGISTERS-1.
REQ-027 All read paths SHALL be combinational with zero-cycle latency; writes and busy updates SHALL take effect one cycle later (visible to the next cycle's reads from storage).
REQ-028 Read ports SHALL be fully independent; any number of ports MAY read the same address.

Reset
REQ-029 While rst=1, all registers, busy, and busy_count SHALL be cleared to zero immediately, regardless of clk.
REQ-030 While rst=1, writes and issues SHALL be ignored; rd_data SHALL reflect cleared storage plus same-cycle write forwarding per REQ-020.
REQ-031 Reset asserted mid-operation SHALL discard all pending busy state; the first posedge after deassertion SHALL process inputs normally.

Verification
REQ-032 Reset, then write 0xDEADBEEF to r5 via port 0, next cycle read r5 on both ports -> both rd_data=0xDEADBEEF, rd_busy=0.
REQ-033 Same cycle: port 0 writes r7=0x11, port 1 writes r7=0x22, read r7 -> forwarded 0x22; next cycle stored 0x22.
REQ-034 Issue r3 (busy_count 0->1), read r3 next cycle -> rd_busy=1; write r3=0x5 -> same-cycle rd_data=0x5, rd_busy=0; next cycle busy[3]=0, busy_count=0.
REQ-035 Same cycle: iss_en with iss_addr=9 and a write r9=0xA -> after edge busy[9]=1, registers[9]=0xA, busy_count=1.
REQ-036 Write r0=0xFFFF and issue r0 -> rd_data for r0=0, busy[0]=0, busy_count unchanged.
REQ-037 Issue r1,r2,r4 over three cycles, assert rst asynchronously between edges -> busy=0, busy_count=0, all reads 0 immediately.

Source files
------------

// File: rtl/sb_regfile.sv
// -----------------------------------------------------------------------------
// sb_regfile
//   Multi-ported register file with an integrated busy scoreboard. Register 0 is
//   hard-wired to zero. Reads are combinational and forward same-cycle write
//   data. The scoreboard marks a destination busy on issue and clears it when a
//   write lands on that register.
//
// Ports
//   clk         : single clock, all state updates on its rising edge
//   rst         : asynchronous active-high reset, clears storage and scoreboard
//   rd_addr     : NUM_READ packed read addresses, port p at [p*AW +: AW]
//   rd_data     : NUM_READ packed read data, combinational, write-forwarded
//   rd_busy     : per read port, addressed register still awaits its write
//   wr_en       : per write port enable
//   wr_addr     : NUM_WRITE packed write addresses
//   wr_data     : NUM_WRITE packed write data
//   iss_en      : mark iss_addr busy (instruction issue)
//   iss_addr    : destination register being issued
//   busy        : registered scoreboard vector
//   busy_count  : registered popcount of busy
// -----------------------------------------------------------------------------
module sb_regfile #(
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_REGISTERS = 32,
    parameter int NUM_READ      = 2,
    parameter int NUM_WRITE     = 2,
    localparam int AW           = $clog2(NUM_REGISTERS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_READ*AW-1:0]           rd_addr,
    output logic [NUM_READ*DATA_WIDTH-1:0]   rd_data,
    output logic [NUM_READ-1:0]              rd_busy,
    input  logic [NUM_WRITE-1:0]             wr_en,
    input  logic [NUM_WRITE*AW-1:0]          wr_addr,
    input  logic [NUM_WRITE*DATA_WIDTH-1:0]  wr_data,
    input  logic                             iss_en,
    input  logic [AW-1:0]                    iss_addr,
    output logic [NUM_REGISTERS-1:0]         busy,
    output logic [AW:0]                      busy_count
);

    logic [DATA_WIDTH-1:0]    regs_q [NUM_REGISTERS];
    logic [DATA_WIDTH-1:0]    regs_d [NUM_REGISTERS];
    logic [NUM_REGISTERS-1:0] busy_q;
    logic [NUM_REGISTERS-1:0] busy_d;
    logic [AW:0]              busy_count_q;
    logic [AW:0]              busy_count_d;

    function automatic logic [AW:0] popcount(input logic [NUM_REGISTERS-1:0] v);
        logic [AW:0] c;
        c = '0;
        for (int i = 0; i < NUM_REGISTERS; i++) begin
            c = c + (AW+1)'(v[i]);
        end
        return c;
    endfunction

    // Next-state: writes applied in ascending port order so the highest-index
    // port wins a same-address collision. Issue is applied after the write
    // clears, so a simultaneous issue keeps the new producer pending.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int w = 0; w < NUM_WRITE; w++) begin
            if (wr_en[w] && (wr_addr[w*AW +: AW] != '0)) begin
                regs_d[wr_addr[w*AW +: AW]] = wr_data[w*DATA_WIDTH +: DATA_WIDTH];
                busy_d[wr_addr[w*AW +: AW]] = 1'b0;
            end
        end
        if (iss_en && (iss_addr != '0)) begin
            busy_d[iss_addr] = 1'b1;
        end
        busy_d[0]    = 1'b0;
        // Count is derived from the next busy vector so both register together.
        busy_count_d = popcount(busy_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGISTERS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q       <= '0;
            busy_count_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REGISTERS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
        end
    end

    // Read ports: stored value, overridden by the highest-index matching write
    // in flight this cycle. A forwarded write also satisfies the busy wait.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int p = 0; p < NUM_READ; p++) begin
            if (rd_addr[p*AW +: AW] != '0) begin
                rd_data[p*DATA_WIDTH +: DATA_WIDTH] = regs_q[rd_addr[p*AW +: AW]];
                rd_busy[p] = busy_q[rd_addr[p*AW +: AW]];
                for (int w = 0; w < NUM_WRITE; w++) begin
                    if (wr_en[w] && (wr_addr[w*AW +: AW] == rd_addr[p*AW +: AW])) begin
                        rd_data[p*DATA_WIDTH +: DATA_WIDTH] = wr_data[w*DATA_WIDTH +: DATA_WIDTH];
                        rd_busy[p] = 1'b0;
                    end
                end
            end
        end
    end

    assign busy       = busy_q;
    assign busy_count = busy_count_q;

endmodule

// File: tb/tb_sb_regfile.sv
module tb_sb_regfile;

    localparam int DW  = 32;
    localparam int NR  = 32;
    localparam int AW  = 5;
    localparam int NRD = 2;
    localparam int NWR = 2;

    localparam int K_RD    = 0;
    localparam int K_RBUSY = 1;
    localparam int K_BUSY  = 2;
    localparam int K_CNT   = 3;

    logic                 clk;
    logic                 rst;
    logic [NRD*AW-1:0]    rd_addr;
    logic [NRD*DW-1:0]    rd_data;
    logic [NRD-1:0]       rd_busy;
    logic [NWR-1:0]       wr_en;
    logic [NWR*AW-1:0]    wr_addr;
    logic [NWR*DW-1:0]    wr_data;
    logic                 iss_en;
    logic [AW-1:0]        iss_addr;
    logic [NR-1:0]        busy;
    logic [AW:0]          busy_count;

    sb_regfile #(
        .DATA_WIDTH(DW), .NUM_REGISTERS(NR), .NUM_READ(NRD), .NUM_WRITE(NWR)
    ) dut (
        .clk(clk), .rst(rst),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr),
        .busy(busy), .busy_count(busy_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        string       tag;
        int          kind;
        int          port;
        logic [31:0] val;
    } exp_t;

    exp_t        sbq[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [DW-1:0] mregs [NR];
    logic [NR-1:0] mbusy;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic push(input string tag, input int kind, input int port, input logic [31:0] val);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.port = port;
        e.val  = val;
        sbq.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] act;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            case (e.kind)
                K_RD:    act = rd_data[e.port*DW +: DW];
                K_RBUSY: act = {31'b0, rd_busy[e.port]};
                K_BUSY:  act = busy;
                default: act = {26'b0, busy_count};
            endcase
            check(e.tag, act, e.val);
        end
    endtask

    function automatic logic [DW-1:0] model_rd(input int p);
        logic [AW-1:0] a;
        logic [DW-1:0] v;
        a = rd_addr[p*AW +: AW];
        if (a == 0) return '0;
        v = mregs[a];
        for (int w = 0; w < NWR; w++)
            if (wr_en[w] && wr_addr[w*AW +: AW] == a) v = wr_data[w*DW +: DW];
        return v;
    endfunction

    function automatic logic model_rbusy(input int p);
        logic [AW-1:0] a;
        a = rd_addr[p*AW +: AW];
        if (a == 0) return 1'b0;
        for (int w = 0; w < NWR; w++)
            if (wr_en[w] && wr_addr[w*AW +: AW] == a) return 1'b0;
        return mbusy[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) mregs[i] = '0;
        mbusy = '0;
    endtask

    task automatic model_step();
        logic [AW-1:0] a;
        if (rst) return;
        for (int w = 0; w < NWR; w++) begin
            a = wr_addr[w*AW +: AW];
            if (wr_en[w] && a != 0) begin
                mregs[a] = wr_data[w*DW +: DW];
                mbusy[a] = 1'b0;
            end
        end
        if (iss_en && iss_addr != 0) mbusy[iss_addr] = 1'b1;
    endtask

    task automatic idle();
        rd_addr  = '0;
        wr_en    = '0;
        wr_addr  = '0;
        wr_data  = '0;
        iss_en   = 1'b0;
        iss_addr = '0;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        rd_addr[p*AW +: AW] = a;
    endtask

    task automatic set_wr(input int w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en[w]             = 1'b1;
        wr_addr[w*AW +: AW]  = a;
        wr_data[w*DW +: DW]  = d;
    endtask

    task automatic issue(input logic [AW-1:0] a);
        iss_en   = 1'b1;
        iss_addr = a;
    endtask

    // Called at posedge+1: let inputs settle and score the combinational reads.
    task automatic settle();
        #2;
        for (int p = 0; p < NRD; p++) begin
            push($sformatf("rd_data%0d", p), K_RD, p, model_rd(p));
            push($sformatf("rd_busy%0d", p), K_RBUSY, p, {31'b0, model_rbusy(p)});
        end
        drain();
    endtask

    // Cross the clock edge and score the registered scoreboard state.
    task automatic edge_chk();
        @(posedge clk);
        model_step();
        #1;
        push("busy", K_BUSY, 0, mbusy);
        push("busy_count", K_CNT, 0, $countones(mbusy));
        drain();
    endtask

    initial begin
        idle();
        model_reset();
        rst = 1'b1;
        #1;
        push("rst_busy", K_BUSY, 0, 32'h0);
        push("rst_cnt", K_CNT, 0, 32'h0);
        set_rd(0, 5'd5);
        set_rd(1, 5'd31);
        #1;
        push("rst_rd0", K_RD, 0, 32'h0);
        push("rst_rd1", K_RD, 1, 32'h0);
        drain();
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;

        // Plain write then read back on both ports
        idle(); set_wr(0, 5'd5, 32'hDEADBEEF);
        settle(); edge_chk();
        idle(); set_rd(0, 5'd5); set_rd(1, 5'd5);
        settle();
        push("r5_p0", K_RD, 0, 32'hDEADBEEF);
        push("r5_p1", K_RD, 1, 32'hDEADBEEF);
        push("r5_busy0", K_RBUSY, 0, 32'h0);
        push("r5_busy1", K_RBUSY, 1, 32'h0);
        drain();
        edge_chk();

        // Write collision: higher port wins, forwarded and stored
        idle(); set_wr(0, 5'd7, 32'h11); set_wr(1, 5'd7, 32'h22); set_rd(0, 5'd7);
        settle();
        push("r7_fwd", K_RD, 0, 32'h22); drain();
        edge_chk();
        idle(); set_rd(0, 5'd7);
        settle();
        push("r7_stored", K_RD, 0, 32'h22); drain();
        edge_chk();

        // Issue, observe busy, satisfy with write
        idle(); issue(5'd3);
        settle(); edge_chk();
        push("iss3_busy", K_BUSY, 0, 32'h8);
        push("iss3_cnt", K_CNT, 0, 32'd1); drain();
        idle(); set_rd(0, 5'd3);
        settle();
        push("r3_rdbusy", K_RBUSY, 0, 32'h1); drain();
        edge_chk();
        idle(); set_rd(0, 5'd3); set_wr(0, 5'd3, 32'h5);
        settle();
        push("r3_fwd", K_RD, 0, 32'h5);
        push("r3_fwd_busy", K_RBUSY, 0, 32'h0); drain();
        edge_chk();
        push("r3_clr_busy", K_BUSY, 0, 32'h0);
        push("r3_clr_cnt", K_CNT, 0, 32'h0); drain();

        // Issue and write same register: issue wins
        idle(); issue(5'd9); set_wr(1, 5'd9, 32'hA);
        settle(); edge_chk();
        push("r9_busy", K_BUSY, 0, 32'h200);
        push("r9_cnt", K_CNT, 0, 32'd1); drain();
        idle(); set_rd(1, 5'd9);
        settle();
        push("r9_data", K_RD, 1, 32'hA);
        push("r9_rdbusy", K_RBUSY, 1, 32'h1); drain();
        edge_chk();

        // Re-issue of a busy register keeps count
        idle(); issue(5'd9);
        settle(); edge_chk();
        push("r9_reiss_cnt", K_CNT, 0, 32'd1); drain();

        // Register 0 is never written nor marked busy
        idle(); set_wr(0, 5'd0, 32'hFFFF); issue(5'd0); set_rd(0, 5'd0); set_rd(1, 5'd0);
        settle();
        push("r0_rd0", K_RD, 0, 32'h0);
        push("r0_rd1", K_RD, 1, 32'h0); drain();
        edge_chk();
        push("r0_busy", K_BUSY, 0, 32'h200);
        push("r0_cnt", K_CNT, 0, 32'd1); drain();

        // Issue r1, r2, r4 then reset asynchronously between edges
        idle(); issue(5'd1); settle(); edge_chk();
        idle(); issue(5'd2); settle(); edge_chk();
        idle(); issue(5'd4); settle(); edge_chk();
        push("pre_rst_busy", K_BUSY, 0, 32'h216);
        push("pre_rst_cnt", K_CNT, 0, 32'd4); drain();
        idle(); set_rd(0, 5'd5); set_rd(1, 5'd7);
        #3 rst = 1'b1;
        #1;
        model_reset();
        push("arst_busy", K_BUSY, 0, 32'h0);
        push("arst_cnt", K_CNT, 0, 32'h0);
        push("arst_rd0", K_RD, 0, 32'h0);
        push("arst_rd1", K_RD, 1, 32'h0); drain();

        // Under reset: forwarding visible, but nothing stored or issued
        set_wr(0, 5'd6, 32'h77); issue(5'd6); set_rd(0, 5'd6);
        #1;
        push("rst_fwd", K_RD, 0, 32'h77); drain();
        @(posedge clk);
        #1;
        idle(); set_rd(0, 5'd6);
        #1;
        push("rst_nowrite", K_RD, 0, 32'h0);
        push("rst_noiss", K_BUSY, 0, 32'h0); drain();
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // First edge after release processes normally
        idle(); set_wr(0, 5'd6, 32'h55); issue(5'd2);
        settle(); edge_chk();
        push("post_rst_busy", K_BUSY, 0, 32'h4);
        push("post_rst_cnt", K_CNT, 0, 32'd1); drain();
        idle(); set_rd(0, 5'd6);
        settle();
        push("post_rst_r6", K_RD, 0, 32'h55); drain();
        edge_chk();

        // Random traffic with a narrow address range to force collisions
        for (int c = 0; c < 400; c++) begin
            idle();
            for (int w = 0; w < NWR; w++)
                if ($urandom_range(0, 1) == 1)
                    set_wr(w, 5'($urandom_range(0, 7)), $urandom);
            if ($urandom_range(0, 2) != 0) issue(5'($urandom_range(0, 7)));
            for (int p = 0; p < NRD; p++) set_rd(p, 5'($urandom_range(0, 7)));
            settle();
            edge_chk();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
